// File: rtl/kbd_event_buffer.sv
// kbd_event_buffer
//   PS/2 keyboard front end. Deserialises device frames, folds E0/F0 prefix
//   bytes into 16-bit key-event words {release, extended, 6'b0, code} and
//   queues them in a small FIFO. The MMU reads one event per rising edge of
//   kbd_en; each read pops the queue.
//
// Ports
//   clk, rst_n      system clock, asynchronous active-low reset
//   ps2_clk/data    raw asynchronous PS/2 pad signals
//   kbd_en          read request (level); its rising edge performs one read
//   kbd_respond     event word for the current read (0 if queue was empty)
//   kbd_r_ready     kbd_respond valid, from 1 cycle after kbd_en rises until it falls
//   kbd_overflow    sticky: an event was dropped because the FIFO was full
//   kbd_count       number of queued events
//
// Configuration
//   KBD_PARITY_CHECK_EN  when defined, frames with even total parity are discarded.
module kbd_event_buffer #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ps2_clk,
  input  logic                        ps2_data,
  input  logic                        kbd_en,
  output logic [15:0]                 kbd_respond,
  output logic                        kbd_r_ready,
  output logic                        kbd_overflow,
  output logic [$clog2(FIFO_DEPTH):0] kbd_count
);
  localparam int HALF_WIDE = 16;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0]  DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} rx_state_e;

  // ---------------------------------------------------------------------------
  // Synchronisers and registered falling-edge detect. The idle PS/2 line is
  // high, so the chain resets to 1 to avoid a phantom edge after reset.
  // ---------------------------------------------------------------------------
  logic [1:0] clk_sync_q, data_sync_q;
  logic       clk_prev_q, fall_q, bit_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_prev_q  <= 1'b1;
      fall_q      <= 1'b0;
      bit_q       <= 1'b1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge value of the others (the chain shifts, not collapses).
      clk_sync_q  <= {clk_sync_q[0], ps2_clk};
      data_sync_q <= {data_sync_q[0], ps2_data};
      clk_prev_q  <= clk_sync_q[1];
      fall_q      <= clk_prev_q & ~clk_sync_q[1];
      bit_q       <= data_sync_q[1];
    end
  end

  // ---------------------------------------------------------------------------
  // Frame receiver with watchdog
  // ---------------------------------------------------------------------------
  rx_state_e      state_q;
  logic [2:0]     bit_cnt_q;
  logic [7:0]     shift_q;
  logic [WDW-1:0] wd_q;
  logic           byte_valid_q;   // one-cycle pulse; shift_q holds the byte
  logic           parity_ok;

`ifdef KBD_PARITY_CHECK_EN
  logic parity_q;
  assign parity_ok = ^{shift_q, parity_q};
`else
  assign parity_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      wd_q         <= '0;
      byte_valid_q <= 1'b0;
`ifdef KBD_PARITY_CHECK_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      byte_valid_q <= 1'b0;
      if (fall_q) begin
        wd_q <= '0;
        unique case (state_q)
          S_IDLE: if (!bit_q) begin
            state_q   <= S_DATA;
            bit_cnt_q <= '0;
          end
          S_DATA: begin
            shift_q   <= {bit_q, shift_q[7:1]};   // LSB arrives first
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_q <= S_PARITY;
          end
          S_PARITY: begin
`ifdef KBD_PARITY_CHECK_EN
            parity_q <= bit_q;
`endif
            state_q  <= S_STOP;
          end
          S_STOP: begin
            state_q      <= S_IDLE;
            byte_valid_q <= bit_q & parity_ok;
          end
          default: state_q <= S_IDLE;
        endcase
      end else if (state_q != S_IDLE) begin
        // A stalled frame is abandoned; the partial byte never reaches the decoder.
        if (wd_q == WD_LAST) begin
          state_q <= S_IDLE;
          wd_q    <= '0;
        end else begin
          wd_q <= wd_q + WDW'(1);
        end
      end else begin
        wd_q <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Prefix decoder
  // ---------------------------------------------------------------------------
  logic                 ext_q, rel_q;
  logic                 push_req;
  logic [HALF_WIDE-1:0] evt;

  assign evt = {rel_q, ext_q, 6'b0, shift_q};

  always_comb begin
    // NOTE: default assigned first so every path drives push_req and no latch is inferred.
    push_req = 1'b0;
    if (byte_valid_q) push_req = !(shift_q inside {8'hE0, 8'hF0, 8'h00});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext_q <= 1'b0;
      rel_q <= 1'b0;
    end else if (byte_valid_q) begin
      if (shift_q == 8'hE0)      ext_q <= 1'b1;
      else if (shift_q == 8'hF0) rel_q <= 1'b1;
      else begin                  // 00 and ordinary codes both consume the prefixes
        ext_q <= 1'b0;
        rel_q <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Event FIFO and read handshake
  // ---------------------------------------------------------------------------
  logic [HALF_WIDE-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]        count_q;
  logic                 ovf_q, kbd_en_q, r_ready_q;
  logic [HALF_WIDE-1:0] respond_q;
  logic                 full, empty, rise, do_push, do_pop;

  assign full    = (count_q == DEPTH_C);
  assign empty   = (count_q == '0);
  assign rise    = kbd_en & ~kbd_en_q;
  assign do_push = push_req & ~full;
  assign do_pop  = rise & ~empty;   // an empty read never pops, even alongside a push

  // NOTE: the storage array has no reset; pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= evt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      kbd_en_q  <= 1'b0;
      r_ready_q <= 1'b0;
      respond_q <= '0;
    end else begin
      kbd_en_q <= kbd_en;
      if (push_req && full) ovf_q <= 1'b1;
      // Pointers are AW bits wide, so they wrap modulo the power-of-two depth.
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (rise) respond_q <= empty ? '0 : mem_q[rd_ptr_q];
      r_ready_q <= kbd_en & (r_ready_q | rise);
    end
  end

  assign kbd_respond  = respond_q;
  assign kbd_r_ready  = r_ready_q;
  assign kbd_overflow = ovf_q;
  assign kbd_count    = count_q;

endmodule

// File: tb/tb_kbd_event_buffer.sv
// Testbench for kbd_event_buffer: table-driven frame sequence, hand-written
// corner cases (overflow, parity, timeout, simultaneous push/pop, reset) and a
// randomized phase checked against a queue-based reference model.
module tb_kbd_event_buffer;
  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 200;
`ifdef KBD_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ps2_clk, ps2_data, kbd_en;
  logic [15:0] kbd_respond;
  logic        kbd_r_ready, kbd_overflow;
  logic [3:0]  kbd_count;

  kbd_event_buffer #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .kbd_en(kbd_en), .kbd_respond(kbd_respond), .kbd_r_ready(kbd_r_ready),
    .kbd_overflow(kbd_overflow), .kbd_count(kbd_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: queue of event words plus prefix flags and sticky overflow.
  logic [15:0] mq[$];
  bit m_ext, m_rel, m_ovf;

  typedef struct {
    logic [7:0] b;
    bit         stop;
    int         exp_count;
  } vec_t;
  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_reset();
    mq.delete();
    m_ext = 0; m_rel = 0; m_ovf = 0;
  endfunction

  function automatic void model_byte(input logic [7:0] b, input bit accepted);
    if (!accepted) return;
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_rel = 1;
    else begin
      if (b != 8'h00) begin
        if (mq.size() < DEPTH) mq.push_back({m_rel, m_ext, 6'b0, b});
        else m_ovf = 1;
      end
      m_ext = 0; m_rel = 0;
    end
  endfunction

  function automatic logic [15:0] model_pop();
    if (mq.size() == 0) return 16'h0000;
    return mq.pop_front();
  endfunction

  task automatic send_bit(input bit v);
    ps2_data = v;
    repeat (2) cyc();
    ps2_clk = 1'b0;
    repeat (4) cyc();
    ps2_clk = 1'b1;
    repeat (2) cyc();
  endtask

  task automatic send_frame(input logic [7:0] b, input bit par_good, input bit stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(par_good ? ~^b : ^b);
    send_bit(stop);
    ps2_data = 1'b1;
    cyc();
    model_byte(b, stop && (par_good || !PAR_EN));
  endtask

  task automatic do_read(input int hold, input string name);
    logic [15:0] exp;
    exp = model_pop();
    kbd_en = 1'b1;
    check({name, "_rdy_pre"}, kbd_r_ready, 0);
    cyc();
    check({name, "_rdy"}, kbd_r_ready, 1);
    check({name, "_data"}, kbd_respond, exp);
    check({name, "_count"}, kbd_count, mq.size());
    repeat (hold) cyc();
    check({name, "_hold"}, kbd_respond, exp);
    check({name, "_rdy_hold"}, kbd_r_ready, 1);
    check({name, "_count_hold"}, kbd_count, mq.size());
    kbd_en = 1'b0;
    cyc();
    check({name, "_rdy_fall"}, kbd_r_ready, 0);
  endtask

  task automatic check_zero(input string name);
    check({name, "_respond"}, kbd_respond, 0);
    check({name, "_rdy"}, kbd_r_ready, 0);
    check({name, "_ovf"}, kbd_overflow, 0);
    check({name, "_count"}, kbd_count, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_zero("reset");
    kbd_en = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1;
    repeat (3) cyc();
    rst_n = 1'b1;
    model_reset();
    repeat (2) cyc();
  endtask

  initial begin
    #500_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    vecs[0] = '{8'hE0, 1'b1, 0};
    vecs[1] = '{8'hF0, 1'b1, 0};
    vecs[2] = '{8'h75, 1'b1, 1};   // C075
    vecs[3] = '{8'h75, 1'b1, 2};   // 0075
    vecs[4] = '{8'h1C, 1'b0, 2};   // bad stop bit: discarded
    vecs[5] = '{8'hF0, 1'b1, 2};
    vecs[6] = '{8'h00, 1'b1, 2};   // 00 drops and clears the pending release
    vecs[7] = '{8'h22, 1'b1, 3};   // 0022
    vecs[8] = '{8'hE0, 1'b1, 3};
    vecs[9] = '{8'h6B, 1'b1, 4};   // 406B

    rst_n = 1'b0; kbd_en = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_zero("init");
    rst_n = 1'b1;
    model_reset();
    repeat (2) cyc();

    // Make code 1C, then a 3-cycle read
    send_frame(8'h1C, 1'b1, 1'b1);
    check("make_count", kbd_count, 1);
    do_read(2, "make");
    check("make_count_after", kbd_count, 0);

    // Table-driven prefix sequence
    foreach (vecs[i]) begin
      send_frame(vecs[i].b, 1'b1, vecs[i].stop);
      check($sformatf("vec%0d_count", i), kbd_count, vecs[i].exp_count);
    end
    for (int i = 0; i < 5; i++) do_read(1, $sformatf("vrd%0d", i));

    // Overflow: 9 make codes into a depth-8 queue
    do_reset();
    for (int i = 0; i < 9; i++) send_frame(8'h10 + 8'(i), 1'b1, 1'b1);
    check("ovf_count", kbd_count, DEPTH);
    check("ovf_flag", kbd_overflow, 1);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("ovf_head%0d", i), mq[0], 16'h0010 + 16'(i));
      do_read(1, $sformatf("ovf_rd%0d", i));
    end
    do_read(1, "ovf_empty");
    check("ovf_sticky", kbd_overflow, 1);

    // Parity: bad parity is dropped only when checking is enabled
    do_reset();
    send_frame(8'h1C, 1'b0, 1'b1);
    check("par_count", kbd_count, mq.size());
    while (mq.size() > 0) do_read(1, "par_drain");

    // Timeout: stall after 4 data bits, then a clean 22 frame
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(i[0]);
    ps2_data = 1'b1;
    repeat (TIMEOUT + 5) cyc();
    send_frame(8'h22, 1'b1, 1'b1);
    check("tmo_count", kbd_count, 1);
    do_read(1, "tmo");

    // Simultaneous push/pop: kbd_en rise lands on the push edge of 33
    do_reset();
    send_frame(8'h1C, 1'b1, 1'b1);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(1'(8'h33 >> i));
    send_bit(~^8'h33);
    ps2_data = 1'b1;
    repeat (2) cyc();
    ps2_clk = 1'b0;
    repeat (4) cyc();
    kbd_en = 1'b1;
    cyc();
    check("pp_count", kbd_count, 1);
    check("pp_rdy", kbd_r_ready, 1);
    check("pp_data", kbd_respond, 16'h001C);
    repeat (3) cyc();
    ps2_clk = 1'b1;
    kbd_en = 1'b0;
    repeat (2) cyc();
    void'(model_pop());
    model_byte(8'h33, 1'b1);
    check("pp_count_after", kbd_count, 1);
    do_read(1, "pp_second");

    // Reset mid-frame (clock low during a data bit)
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    ps2_data = 1'b0;
    repeat (2) cyc();
    ps2_clk = 1'b0;
    repeat (2) cyc();
    do_reset();
    send_frame(8'h1C, 1'b1, 1'b1);
    do_read(1, "rst_frame");

    // Reset while kbd_r_ready is high with an event still queued
    send_frame(8'h1C, 1'b1, 1'b1);
    send_frame(8'h2A, 1'b1, 1'b1);
    kbd_en = 1'b1;
    cyc();
    check("rst_rd_rdy", kbd_r_ready, 1);
    check("rst_rd_count", kbd_count, 1);
    do_reset();
    send_frame(8'h5A, 1'b1, 1'b1);
    do_read(1, "rst_read");

    // Randomized mix of frames and reads against the model
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 9) < 6) begin
        logic [7:0] b;
        int sel;
        sel = $urandom_range(0, 9);
        b = (sel == 0) ? 8'hE0 : (sel == 1) ? 8'hF0 : (sel == 2) ? 8'h00 : 8'($urandom_range(1, 255));
        send_frame(b, $urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0);
        check($sformatf("rnd%0d_count", it), kbd_count, mq.size());
        check($sformatf("rnd%0d_ovf", it), kbd_overflow, m_ovf);
      end else begin
        do_read($urandom_range(0, 2), $sformatf("rnd%0d_rd", it));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
